// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets one of NUM_REQ requesters push bursts of up to
// MAX_BURST words into a downstream sync FIFO, honouring the FIFO full flag.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  beat_cnt;
  logic [ID_W-1:0]   sel;
  logic [ID_W-1:0]   sel_nxt;
  logic [ID_W-1:0]   idx;
  logic              own_valid;
  logic              xfer;
  logic              last_beat;

  // Walk backwards so the closest set bit at or after rr_ptr wins.
  always_comb begin
    sel = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[idx]) sel = idx;
    end
  end

  assign sel_nxt   = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
  assign busy      = (state == GRANT);
  assign own_valid = req_valid[grant_id];
  assign xfer      = busy & own_valid & ~fifo_full;
  assign last_beat = (beat_cnt == CNT_W'(MAX_BURST - 1));
  assign fifo_w_en = xfer;
  assign fifo_data = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign req_ready[i] = busy & ~fifo_full & (grant_id == ID_W'(i));
  end

  // Owner dropping valid releases even under a full stall, so a stalled
  // grant can never lock out the other requesters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state    <= GRANT;
            grant_id <= sel;
            rr_ptr   <= sel_nxt;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (xfer) beat_cnt <= beat_cnt + 1'b1;
          if ((xfer && last_beat) || !own_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: each requester presents {id, seq} words
// and a write monitor checks every FIFO write against per-requester order.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic          fifo_full;
  logic          fifo_w_en;
  logic [DW-1:0] fifo_data;
  logic [1:0]    grant_id;
  logic          busy;

  int n_run  = 0;
  int n_fail = 0;

  logic [5:0]    seq    [NR];
  logic [5:0]    wr_cnt [NR];
  logic [NR-1:0] fire_q;
  int            wr_scn;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_w_en(fifo_w_en),
    .fifo_data(fifo_data), .grant_id(grant_id), .busy(busy)
  );

  for (genvar g = 0; g < NR; g++) begin : g_src
    assign req_data[g*DW +: DW] = {2'(g), seq[g]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every word must come from the owner, in order, never when full.
  always @(negedge clk) begin
    fire_q = rst_n ? (req_valid & req_ready) : '0;
    if (rst_n) begin
      chk("no_full_write", {31'd0, fifo_w_en & fifo_full}, 32'd0);
      chk("wen_vs_accept", {31'd0, fifo_w_en}, {31'd0, |fire_q});
      if (fifo_w_en) begin
        chk("wr_owner", {30'd0, fifo_data[7:6]}, {30'd0, grant_id});
        chk("wr_order", {26'd0, fifo_data[5:0]}, {26'd0, wr_cnt[fifo_data[7:6]]});
        wr_cnt[fifo_data[7:6]] = wr_cnt[fifo_data[7:6]] + 6'd1;
        wr_scn++;
      end
    end
  end

  always @(posedge clk)
    for (int i = 0; i < NR; i++) if (fire_q[i]) seq[i] <= seq[i] + 6'd1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wr_scn = 0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin seq[i] = '0; wr_cnt[i] = '0; end
    fire_q = '0; wr_scn = 0;
    rst_n = 1'b0; req_valid = '1; fifo_full = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wen", {31'd0, fifo_w_en}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);

    // Single requester 2: bubble, 4 beats, bubble, regrant.
    do_reset();
    req_valid = 4'b0100;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("a_busy%0d", c), {31'd0, busy}, {31'd0, (c != 0 && c != 5)});
      chk($sformatf("a_wen%0d", c), {31'd0, fifo_w_en}, {31'd0, (c != 0 && c != 5)});
      if (c >= 1 && c <= 4)
        chk($sformatf("a_data%0d", c), {24'd0, fifo_data}, {24'd0, 2'd2, 6'(c - 1)});
      if (c == 6) chk("a_regrant", {30'd0, grant_id}, 32'd2);
      tick();
    end

    // All valid: 0,1,2,3,0,... each MAX_BURST beats with a bubble between.
    do_reset();
    req_valid = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk($sformatf("b_busy%0d", c), {31'd0, busy}, {31'd0, (c % 5 != 0)});
      if (c % 5 != 0) chk($sformatf("b_gid%0d", c), {30'd0, grant_id}, 32'((c / 5) % 4));
      tick();
    end
    chk("b_writes", 32'(wr_scn), 32'd32);

    // Owner 1 stalled by fifo_full for 5 cycles after two beats.
    do_reset();
    req_valid = 4'b0010;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("c_busy%0d", c), {31'd0, busy}, {31'd0, (c >= 1 && c <= 9)});
      chk($sformatf("c_wen%0d", c), {31'd0, fifo_w_en},
          {31'd0, (c == 1 || c == 2 || c == 8 || c == 9)});
      chk($sformatf("c_rdy%0d", c), {28'd0, req_ready},
          (c == 1 || c == 2 || c == 8 || c == 9) ? 32'd2 : 32'd0);
      tick();
      if (c + 1 == 3) fifo_full = 1'b1;
      if (c + 1 == 8) fifo_full = 1'b0;
    end
    chk("c_writes", 32'(wr_scn), 32'd4);

    // Owner 0 drops after one beat; requester 1 idle, so 2 is next.
    do_reset();
    req_valid = 4'b0101;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("d_busy%0d", c), {31'd0, busy}, {31'd0, (c != 0 && c != 3)});
      chk($sformatf("d_wen%0d", c), {31'd0, fifo_w_en}, {31'd0, (c == 1 || c == 4)});
      if (c == 1) chk("d_gid_first", {30'd0, grant_id}, 32'd0);
      if (c == 4) chk("d_gid_next", {30'd0, grant_id}, 32'd2);
      tick();
      if (c == 1) req_valid = 4'b0100;
    end

    // Reset during beat 3 of requester 3, then 4'b1010 must grant 1 first.
    do_reset();
    req_valid = 4'b1000;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      chk($sformatf("e_wen%0d", c), {31'd0, fifo_w_en}, {31'd0, (c != 0)});
      tick();
    end
    chk("e_beat3_live", {31'd0, fifo_w_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("e_rst_busy", {31'd0, busy}, 32'd0);
    chk("e_rst_wen", {31'd0, fifo_w_en}, 32'd0);
    chk("e_rst_ready", {28'd0, req_ready}, 32'd0);
    chk("e_writes", 32'(wr_scn), 32'd2);
    tick();
    rst_n = 1'b1; req_valid = 4'b1010;
    @(negedge clk);
    chk("e_idle", {31'd0, busy}, 32'd0);
    tick();
    @(negedge clk);
    chk("e_busy", {31'd0, busy}, 32'd1);
    chk("e_gid", {30'd0, grant_id}, 32'd1);
    tick();

    // Random traffic; the write monitor checks order and full protection.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      tick();
    end
    req_valid = '0; fifo_full = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < NR; i++)
      chk($sformatf("lost_words%0d", i), {26'd0, wr_cnt[i]}, {26'd0, seq[i]});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
